// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM bus; MEM has fixed priority over IF; 1/2/4-byte accesses serialized little-endian.
// Latency: N-byte read reports Done N+1 edges after acceptance, N-byte write after N edges; all outputs registered.
// Backpressure: requesters stall on Busy/Done status; with IO_FULL_STALL_EN, I/O stores (addr[17:16]==11) hold while io_full.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic [1:0]        if_status,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_times,
    input  logic [1:0]        mem_readwrite,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_status,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_full
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    state_t            state, state_nxt;
    logic              gnt_mem, gnt_mem_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [DATA_W-1:0] wdat, wdat_nxt;
    logic [2:0]        nb, nb_nxt;
    logic [2:0]        cnt, cnt_nxt, cnt_inc;
    logic [1:0]        lane;
    logic [DATA_W-1:0] rbuf, rbuf_nxt;
    logic [DATA_W-1:0] if_data_nxt, mem_rdata_nxt;
    logic [1:0]        if_status_nxt, mem_status_nxt;
    logic [ADDR_W-1:0] ram_a_nxt;
    logic [7:0]        ram_dout_nxt;
    logic              ram_wr_nxt;
    logic              mem_vld, mem_store;
    logic              stall_new, stall_cur;

    assign mem_vld   = ((mem_readwrite == 2'b01) || (mem_readwrite == 2'b10)) &&
                       ((mem_times == 3'b001) || (mem_times == 3'b010) || (mem_times == 3'b100));
    assign mem_store = (mem_readwrite == 2'b10);

`ifdef IO_FULL_STALL_EN
    // stall_new looks at the address being accepted, stall_cur at the latched one
    assign stall_new = io_full && (mem_addr[17:16] == 2'b11);
    assign stall_cur = io_full && (base[17:16] == 2'b11);
`else
    logic unused_io_full;
    assign unused_io_full = io_full;
    assign stall_new      = 1'b0;
    assign stall_cur      = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        gnt_mem_nxt    = gnt_mem;
        base_nxt       = base;
        wdat_nxt       = wdat;
        nb_nxt         = nb;
        cnt_nxt        = cnt;
        rbuf_nxt       = rbuf;
        if_data_nxt    = if_data;
        mem_rdata_nxt  = mem_rdata;
        if_status_nxt  = if_status;
        mem_status_nxt = mem_status;
        ram_a_nxt      = ram_a;
        ram_dout_nxt   = ram_dout;
        ram_wr_nxt     = 1'b0;
        cnt_inc        = cnt + 3'd1;
        lane           = cnt[1:0] - 2'd1;

        case (state)
            IDLE: begin
                if_status_nxt  = ST_INIT;
                mem_status_nxt = ST_INIT;
                if (mem_vld) begin
                    gnt_mem_nxt    = 1'b1;
                    base_nxt       = mem_addr;
                    wdat_nxt       = mem_wdata;
                    nb_nxt         = mem_times;
                    rbuf_nxt       = '0;
                    mem_status_nxt = ST_BUSY;
                    if (mem_store) begin
                        state_nxt = WR;
                        if (stall_new) begin
                            cnt_nxt = 3'd0;
                        end else begin
                            ram_wr_nxt   = 1'b1;
                            ram_a_nxt    = mem_addr;
                            ram_dout_nxt = mem_wdata[7:0];
                            cnt_nxt      = 3'd1;
                        end
                    end else begin
                        state_nxt = RD;
                        ram_a_nxt = mem_addr;
                        cnt_nxt   = 3'd0;
                    end
                end else if (if_req) begin
                    gnt_mem_nxt   = 1'b0;
                    base_nxt      = if_addr;
                    nb_nxt        = 3'd4;
                    rbuf_nxt      = '0;
                    if_status_nxt = ST_BUSY;
                    state_nxt     = RD;
                    ram_a_nxt     = if_addr;
                    cnt_nxt       = 3'd0;
                end
            end
            RD: begin
                // cnt counts edges since acceptance; byte i arrives two edges after its address
                cnt_nxt = cnt_inc;
                if (cnt_inc < nb) begin
                    ram_a_nxt = base + ADDR_W'(cnt_inc);
                end
                if (cnt != 3'd0) begin
                    rbuf_nxt[{lane, 3'b000} +: 8] = ram_din;
                end
                if (cnt == nb) begin
                    state_nxt = DONE;
                    if (gnt_mem) begin
                        mem_rdata_nxt  = rbuf_nxt;
                        mem_status_nxt = ST_DONE;
                    end else begin
                        if_data_nxt   = rbuf_nxt;
                        if_status_nxt = ST_DONE;
                    end
                end
            end
            WR: begin
                // cnt is the number of bytes already presented
                if (cnt == nb) begin
                    state_nxt      = DONE;
                    mem_status_nxt = ST_DONE;
                end else if (!stall_cur) begin
                    ram_wr_nxt   = 1'b1;
                    ram_a_nxt    = base + ADDR_W'(cnt);
                    ram_dout_nxt = wdat[{cnt[1:0], 3'b000} +: 8];
                    cnt_nxt      = cnt_inc;
                end
            end
            DONE: begin
                state_nxt      = IDLE;
                if_status_nxt  = ST_INIT;
                mem_status_nxt = ST_INIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_mem    <= 1'b0;
            base       <= '0;
            wdat       <= '0;
            nb         <= 3'd0;
            cnt        <= 3'd0;
            rbuf       <= '0;
            if_data    <= '0;
            mem_rdata  <= '0;
            if_status  <= ST_INIT;
            mem_status <= ST_INIT;
            ram_a      <= '0;
            ram_dout   <= 8'd0;
            ram_wr     <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt_mem    <= gnt_mem_nxt;
            base       <= base_nxt;
            wdat       <= wdat_nxt;
            nb         <= nb_nxt;
            cnt        <= cnt_nxt;
            rbuf       <= rbuf_nxt;
            if_data    <= if_data_nxt;
            mem_rdata  <= mem_rdata_nxt;
            if_status  <= if_status_nxt;
            mem_status <= mem_status_nxt;
            ram_a      <= ram_a_nxt;
            ram_dout   <= ram_dout_nxt;
            ram_wr     <= ram_wr_nxt;
        end
    end

endmodule
